// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared types and constants for the rv32m execute-path units
// (shift_add_multiplier / shift_sub_divider).
//   div_state_t   : divider FSM state encoding
//   DIV_BY_ZERO_Q : fill bit for the divide-by-zero quotient (all ones)
package rv32m_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    ADJUST = 2'd2,
    DONE   = 2'd3
  } div_state_t;

  // Replicated to the operand width at the point of use.
  localparam logic DIV_BY_ZERO_Q = 1'b1;

endpackage

// File: rtl/shift_sub_divider.sv
// shift_sub_divider: radix-2 restoring shift-subtract divider for RV32M
// DIV/DIVU/REM/REMU. One quotient bit per cycle; quotient and remainder are
// returned together and the caller selects which to use.
//
// Parameters:
//   N          operand / result width (default 32)
// Ports:
//   CLK        clock, all state updates on posedge
//   RST        asynchronous active-high reset
//   dividend   dividend, sampled on the edge that accepts start
//   divisor    divisor, sampled on the edge that accepts start
//   is_signed  1 = two's complement operands (DIV/REM), 0 = unsigned
//   start      request, accepted only in IDLE or DONE
//   finished   high in DONE; quotient/remainder valid while high
//   quotient   result quotient
//   remainder  result remainder
//
// Configuration macro:
//   DIVIDER_EARLY_OUT_EN  when defined, operands with |divisor| > |dividend|
//                         complete in one cycle (q=0, r=dividend). Results
//                         are identical either way; only latency differs.
//
// Latency: accept at edge k -> finished high after edge k+N+2
// (divide-by-zero, and early-out when enabled: after edge k+1).
module shift_sub_divider #(
  parameter int N = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         is_signed,
  input  logic         start,
  output logic         finished,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  import rv32m_pkg::*;

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic [N-1:0]     dvd;      // dividend magnitude, shifted out MSB first
  logic [N-1:0]     dsr;      // divisor magnitude
  logic [N-1:0]     q_acc;    // quotient magnitude under construction
  logic [N-1:0]     rem_acc;  // partial remainder magnitude
  logic             neg_q;
  logic             neg_r;

  // Operand magnitudes for the accept edge.
  logic         dvd_neg;
  logic         dsr_neg;
  logic [N-1:0] dvd_mag;
  logic [N-1:0] dsr_mag;

  always_comb begin
    dvd_neg = is_signed & dividend[N-1];
    dsr_neg = is_signed & divisor[N-1];
    dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
    dsr_mag = dsr_neg ? (~divisor + 1'b1) : divisor;
  end

  // One restoring step. The shifted partial remainder needs N+1 bits for the
  // compare; the difference always fits in N bits because it is < dsr.
  logic [N:0]   rem_shift;
  logic         rem_ge;
  logic [N-1:0] rem_next;

  always_comb begin
    rem_shift = {rem_acc, dvd[N-1]};
    rem_ge    = (rem_shift >= {1'b0, dsr});
    rem_next  = rem_ge ? (rem_shift[N-1:0] - dsr) : rem_shift[N-1:0];
  end

`ifdef DIVIDER_EARLY_OUT_EN
  logic early_out;
  always_comb early_out = (dsr_mag > dvd_mag);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      count     <= '0;
      dvd       <= '0;
      dsr       <= '0;
      q_acc     <= '0;
      rem_acc   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      finished  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvd      <= dvd_mag;
            dsr      <= dsr_mag;
            neg_q    <= dvd_neg ^ dsr_neg;
            neg_r    <= dvd_neg;
            q_acc    <= '0;
            rem_acc  <= '0;
            count    <= CNT_INIT;
            finished <= 1'b0;
            if (divisor == '0) begin
              // RISC-V divide-by-zero result; sign fixup bypassed.
              quotient  <= {N{DIV_BY_ZERO_Q}};
              remainder <= dividend;
              state     <= DONE;
            end
`ifdef DIVIDER_EARLY_OUT_EN
            else if (early_out) begin
              quotient  <= '0;
              remainder <= dividend;
              state     <= DONE;
            end
`endif
            else begin
              state <= DIVIDE;
            end
          end else if (state == DONE) begin
            // finished trails entry into DONE by one cycle.
            finished <= 1'b1;
          end
        end

        DIVIDE: begin
          dvd     <= {dvd[N-2:0], 1'b0};
          rem_acc <= rem_next;
          q_acc   <= {q_acc[N-2:0], rem_ge};
          count   <= count - 1'b1;
          if (count == CNT_LAST) state <= ADJUST;
        end

        ADJUST: begin
          quotient  <= neg_q ? (~q_acc + 1'b1) : q_acc;
          remainder <= neg_r ? (~rem_acc + 1'b1) : rem_acc;
          state     <= DONE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
